// File: rtl/fb_pkg.sv
// rtl/fb_pkg.sv - shared types and constants for the framebuffer port arbiter
//
// Holds the framebuffer geometry, the per-cycle grant encoding, the response
// tag carried alongside a RAM read, and the address range helper.

package fb_pkg;

    localparam int FB_WORDS = 19200;   // 160x120 bytes
    localparam int AW       = 15;
    localparam int DW       = 8;

    typedef enum logic [1:0] {
        GNT_NONE = 2'd0,
        GNT_DISP = 2'd1,
        GNT_WR   = 2'd2,
        GNT_RD   = 2'd3
    } grant_e;

    typedef enum logic [1:0] {
        TAG_NONE = 2'd0,
        TAG_DISP = 2'd1,
        TAG_RD   = 2'd2
    } tag_e;

    // Last requester served by the writer/reader round-robin.
    typedef enum logic {
        RR_WR = 1'b0,
        RR_RD = 1'b1
    } rr_last_e;

    // Tag travelling with a RAM read; oor forces the returned byte to zero.
    typedef struct packed {
        tag_e tag;
        logic oor;
    } resp_tag_t;

    function automatic logic fb_addr_ok(input logic [31:0] addr, input logic [31:0] limit);
        return addr < limit;
    endfunction

endpackage

// File: rtl/fb_rr_arbiter.sv
// rtl/fb_rr_arbiter.sv - two-way writer/reader round-robin with enable
//
// Ports:
//   clk, rst_n       clock, synchronous active-low reset
//   en               arbitration allowed this cycle (low while display pending)
//   req_wr, req_rd   request lines (valid of each requester)
//   gnt_wr, gnt_rd   one-hot grant, combinational
//
// The last-served pointer moves only when a grant is actually issued and
// resets to RD so the writer wins the first contested cycle.

module fb_rr_arbiter
    import fb_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    input  logic req_wr,
    input  logic req_rd,
    output logic gnt_wr,
    output logic gnt_rd
);

    rr_last_e last_q;
    rr_last_e last_d;

    always_comb begin
        gnt_wr = 1'b0;
        gnt_rd = 1'b0;
        if (en) begin
            if (req_wr && req_rd) begin
                gnt_wr = (last_q == RR_RD);
                gnt_rd = (last_q == RR_WR);
            end else begin
                gnt_wr = req_wr;
                gnt_rd = req_rd;
            end
        end

        last_d = last_q;
        if (gnt_wr) begin
            last_d = RR_WR;
        end else if (gnt_rd) begin
            last_d = RR_RD;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            last_q <= RR_RD;
        end else begin
            last_q <= last_d;
        end
    end

endmodule

// File: rtl/fb_port_arbiter.sv
// rtl/fb_port_arbiter.sv - single-port framebuffer scheduler: display, writer, reader
//
// Ports:
//   i_CLK, i_RST_N                    clock, synchronous active-low reset
//   i_DispAddr / o_DispData           display fetch address, registered pixel
//   i_WrValid/o_WrReady/i_WrAddr/i_WrData   writer handshake
//   i_RdValid/o_RdReady/i_RdAddr      reader request handshake
//   o_RdDataValid / o_RdData          one-cycle read response (accept + 2)
//   o_MemAddr/o_MemWe/o_MemWData      RAM port, combinational from the grant
//   i_MemRData                        RAM read data, one cycle after address
//
// Display fetches always win so scan-out never stalls; the remaining cycles
// are shared between writer and reader by fb_rr_arbiter.

module fb_port_arbiter #(
    parameter int FB_WORDS = fb_pkg::FB_WORDS,
    parameter int AW       = fb_pkg::AW,
    parameter int DW       = fb_pkg::DW
) (
    input  logic          i_CLK,
    input  logic          i_RST_N,
    input  logic [AW-1:0] i_DispAddr,
    output logic [DW-1:0] o_DispData,
    input  logic          i_WrValid,
    output logic          o_WrReady,
    input  logic [AW-1:0] i_WrAddr,
    input  logic [DW-1:0] i_WrData,
    input  logic          i_RdValid,
    output logic          o_RdReady,
    input  logic [AW-1:0] i_RdAddr,
    output logic          o_RdDataValid,
    output logic [DW-1:0] o_RdData,
    output logic [AW-1:0] o_MemAddr,
    output logic          o_MemWe,
    output logic [DW-1:0] o_MemWData,
    input  logic [DW-1:0] i_MemRData
);

    import fb_pkg::*;

    localparam logic [31:0] FB_LIMIT = 32'(FB_WORDS);

    logic [AW-1:0] last_fetched_q, last_fetched_d;
    logic          force_q, force_d;
    resp_tag_t     tag_q, tag_d;
    logic [DW-1:0] disp_data_q, disp_data_d;
    logic          rd_valid_q, rd_valid_d;
    logic [DW-1:0] rd_data_q, rd_data_d;

    logic          disp_pend;
    logic          rr_en;
    logic          rr_gnt_wr, rr_gnt_rd;
    grant_e        grant;
    logic          disp_ok, wr_ok, rd_ok;
    logic          wr_hit;
    logic [DW-1:0] resp_data;

    assign disp_ok = fb_addr_ok(32'(i_DispAddr), FB_LIMIT);
    assign wr_ok   = fb_addr_ok(32'(i_WrAddr), FB_LIMIT);
    assign rd_ok   = fb_addr_ok(32'(i_RdAddr), FB_LIMIT);

    // force_q covers the first fetch after reset and refetches after a
    // write landed on the pixel currently shown.
    assign disp_pend = force_q || (i_DispAddr != last_fetched_q);
    assign rr_en     = i_RST_N && !disp_pend;

    fb_rr_arbiter u_rr (
        .clk    (i_CLK),
        .rst_n  (i_RST_N),
        .en     (rr_en),
        .req_wr (i_WrValid),
        .req_rd (i_RdValid),
        .gnt_wr (rr_gnt_wr),
        .gnt_rd (rr_gnt_rd)
    );

    always_comb begin
        grant = GNT_NONE;
        if (i_RST_N) begin
            if (disp_pend) begin
                grant = GNT_DISP;
            end else if (rr_gnt_wr) begin
                grant = GNT_WR;
            end else if (rr_gnt_rd) begin
                grant = GNT_RD;
            end
        end
    end

    assign o_WrReady = (grant == GNT_WR);
    assign o_RdReady = (grant == GNT_RD);

    // RAM mux and request-side state
    always_comb begin
        o_MemAddr      = '0;
        o_MemWe        = 1'b0;
        o_MemWData     = '0;
        tag_d.tag      = TAG_NONE;
        tag_d.oor      = 1'b0;
        last_fetched_d = last_fetched_q;
        force_d        = force_q;
        wr_hit         = 1'b0;

        unique case (grant)
            GNT_DISP: begin
                o_MemAddr      = i_DispAddr;
                last_fetched_d = i_DispAddr;
                tag_d.tag      = TAG_DISP;
                tag_d.oor      = !disp_ok;
                force_d        = 1'b0;
            end
            GNT_WR: begin
                o_MemAddr  = i_WrAddr;
                o_MemWe    = wr_ok;
                o_MemWData = i_WrData;
                wr_hit     = wr_ok && (i_WrAddr == last_fetched_q);
            end
            GNT_RD: begin
                o_MemAddr = i_RdAddr;
                tag_d.tag = TAG_RD;
                tag_d.oor = !rd_ok;
            end
            GNT_NONE: begin
            end
        endcase

        if (wr_hit) begin
            force_d = 1'b1;
        end
    end

    // Response side: RAM data arrives one cycle after the tag was captured.
    always_comb begin
        resp_data   = tag_q.oor ? '0 : i_MemRData;
        disp_data_d = disp_data_q;
        rd_data_d   = rd_data_q;
        rd_valid_d  = 1'b0;
        case (tag_q.tag)
            TAG_DISP: disp_data_d = resp_data;
            TAG_RD: begin
                rd_valid_d = 1'b1;
                rd_data_d  = resp_data;
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge i_CLK) begin
        if (!i_RST_N) begin
            last_fetched_q <= '0;
            force_q        <= 1'b1;
            tag_q          <= '{tag: TAG_NONE, oor: 1'b0};
            disp_data_q    <= '0;
            rd_valid_q     <= 1'b0;
            rd_data_q      <= '0;
        end else begin
            last_fetched_q <= last_fetched_d;
            force_q        <= force_d;
            tag_q          <= tag_d;
            disp_data_q    <= disp_data_d;
            rd_valid_q     <= rd_valid_d;
            rd_data_q      <= rd_data_d;
        end
    end

    assign o_DispData    = disp_data_q;
    assign o_RdDataValid = rd_valid_q;
    assign o_RdData      = rd_data_q;

endmodule
